// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, status bit positions, FSM state types and
// oversampling constants shared by the buffered UART and its FIFO.
package uart_pkg;

  localparam logic [7:0] REG_STAT = 8'd0;
  localparam logic [7:0] REG_DATA = 8'd1;
  localparam logic [7:0] REG_DIV  = 8'd2;

  localparam int unsigned ST_RX_AVAIL   = 0;
  localparam int unsigned ST_TX_FULL    = 1;
  localparam int unsigned ST_TX_IDLE    = 2;
  localparam int unsigned ST_OVERRUN    = 3;
  localparam int unsigned ST_FRAME_ERR  = 4;
  localparam int unsigned ST_PARITY_ERR = 5;
  localparam int unsigned ST_PAR_EN     = 6;
  localparam int unsigned ST_PAR_ODD    = 7;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_BIT    = 8;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_ERR
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO with extra-MSB pointers for full/empty.
// Pop of empty is ignored; push of full is ignored unless a pop happens
// in the same cycle, in which case both take effect.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_buffered.sv
// uart_buffered: memory-mapped UART with programmable baud divisor,
// 5..8 data bits, optional parity, RX/TX FIFOs and sticky error flags.
// Define UART_IRQ_EN to add a registered level-sensitive irq output.
module uart_buffered
  import uart_pkg::*;
#(
  parameter logic [7:0]  UART_ADDRESS    = 8'h00,
  parameter int unsigned DATA_BITS       = 8,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter logic [7:0]  DEFAULT_DIVISOR = 8'd103
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic [7:0] address,
  input  logic       w_en,
  input  logic       r_en,
  output logic [7:0] dout,
  input  logic       rx,
`ifdef UART_IRQ_EN
  output logic       irq,
`endif
  output logic       tx
);
  localparam logic [7:0] ADDR_STAT = UART_ADDRESS + REG_STAT;
  localparam logic [7:0] ADDR_DATA = UART_ADDRESS + REG_DATA;
  localparam logic [7:0] ADDR_DIV  = UART_ADDRESS + REG_DIV;
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_LAST  = 4'(MID_BIT - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

  logic wr_stat, wr_data, wr_div, rd_stat, rd_data, rd_div;
  logic [7:0] divisor, div_active, tick_cnt;
  logic tick;
  logic par_en, par_odd, overrun, frame_err, parity_err;
  logic set_ovr, set_ferr, set_perr;
  logic [7:0] status, rx_head_ext;

  logic rx_meta, rx_sync;
  rx_state_t rx_state, rx_state_n;
  logic [3:0] rx_tcnt, rx_tcnt_n;
  logic [2:0] rx_bcnt, rx_bcnt_n;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n, rx_head;
  logic rx_pen, rx_pen_n, rx_podd, rx_podd_n, rx_bad, rx_bad_n;
  logic rx_push, rx_full, rx_empty;

  tx_state_t tx_state, tx_state_n;
  logic [3:0] tx_tcnt, tx_tcnt_n;
  logic [2:0] tx_bcnt, tx_bcnt_n;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_n, tx_head;
  logic tx_pen, tx_pen_n, tx_pbit, tx_pbit_n, tx_n;
  logic tx_pop, tx_full, tx_empty;

  assign wr_stat = w_en && (address == ADDR_STAT);
  assign wr_data = w_en && (address == ADDR_DATA);
  assign wr_div  = w_en && (address == ADDR_DIV);
  assign rd_stat = r_en && (address == ADDR_STAT);
  assign rd_data = r_en && (address == ADDR_DATA);
  assign rd_div  = r_en && (address == ADDR_DIV);

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .wdata(rx_shift),
    .pop(rd_data), .rdata(rx_head), .full(rx_full), .empty(rx_empty)
  );

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(wr_data), .wdata(din[DATA_BITS-1:0]),
    .pop(tx_pop), .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );

  // Tick generator; the divisor is sampled only at reload so a running period is never cut short
  assign tick = (tick_cnt == div_active);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt   <= '0;
      div_active <= DEFAULT_DIVISOR;
    end else if (tick) begin
      tick_cnt   <= '0;
      div_active <= divisor;
    end else begin
      tick_cnt <= tick_cnt + 8'd1;
    end
  end

  // Overrun only when the push finds the FIFO full and no pop frees a slot this cycle
  assign set_ovr = rx_push && rx_full && !rd_data;

  // Control bits, divisor and sticky flags (a set in the same cycle as a clear wins)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor    <= DEFAULT_DIVISOR;
      par_en     <= 1'b0;
      par_odd    <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (wr_div) divisor <= din;
      if (wr_stat) begin
        par_odd <= din[ST_PAR_ODD];
        par_en  <= din[ST_PAR_EN];
      end
      overrun    <= set_ovr  | (overrun    & ~(wr_stat & din[ST_OVERRUN]));
      frame_err  <= set_ferr | (frame_err  & ~(wr_stat & din[ST_FRAME_ERR]));
      parity_err <= set_perr | (parity_err & ~(wr_stat & din[ST_PARITY_ERR]));
    end
  end

  // Status word and zero-extended RX head
  always_comb begin
    status                = '0;
    status[ST_RX_AVAIL]   = !rx_empty;
    status[ST_TX_FULL]    = tx_full;
    status[ST_TX_IDLE]    = tx_empty && (tx_state == TX_IDLE);
    status[ST_OVERRUN]    = overrun;
    status[ST_FRAME_ERR]  = frame_err;
    status[ST_PARITY_ERR] = parity_err;
    status[ST_PAR_EN]     = par_en;
    status[ST_PAR_ODD]    = par_odd;
    rx_head_ext                  = '0;
    rx_head_ext[DATA_BITS-1:0]   = rx_head;
  end

  // Registered read data, held when no in-window read occurs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (rd_stat) begin
      dout <= status;
    end else if (rd_data) begin
      dout <= rx_empty ? '0 : rx_head_ext;
    end else if (rd_div) begin
      dout <= divisor;
    end
  end

  // Two-flop synchroniser for the asynchronous serial input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // RX state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_tcnt  <= '0;
      rx_bcnt  <= '0;
      rx_shift <= '0;
      rx_pen   <= 1'b0;
      rx_podd  <= 1'b0;
      rx_bad   <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_tcnt  <= rx_tcnt_n;
      rx_bcnt  <= rx_bcnt_n;
      rx_shift <= rx_shift_n;
      rx_pen   <= rx_pen_n;
      rx_podd  <= rx_podd_n;
      rx_bad   <= rx_bad_n;
    end
  end

  // RX next state: parity config is latched at the start edge so a frame in flight is unaffected
  always_comb begin
    rx_state_n = rx_state;
    rx_tcnt_n  = rx_tcnt;
    rx_bcnt_n  = rx_bcnt;
    rx_shift_n = rx_shift;
    rx_pen_n   = rx_pen;
    rx_podd_n  = rx_podd;
    rx_bad_n   = rx_bad;
    rx_push    = 1'b0;
    set_ferr   = 1'b0;
    set_perr   = 1'b0;
    if (tick) begin
      case (rx_state)
        RX_IDLE: begin
          if (!rx_sync) begin
            rx_state_n = RX_START;
            rx_tcnt_n  = '0;
            rx_pen_n   = par_en;
            rx_podd_n  = par_odd;
            rx_bad_n   = 1'b0;
          end
        end
        RX_START: begin
          if (rx_tcnt == MID_LAST) begin
            rx_tcnt_n = '0;
            rx_bcnt_n = '0;
            rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_tcnt_n = rx_tcnt + 4'd1;
          end
        end
        RX_DATA: begin
          if (rx_tcnt == TICK_LAST) begin
            rx_tcnt_n  = '0;
            rx_shift_n = {rx_sync, rx_shift[DATA_BITS-1:1]};
            if (rx_bcnt == BIT_LAST) rx_state_n = rx_pen ? RX_PARITY : RX_STOP;
            else                     rx_bcnt_n  = rx_bcnt + 3'd1;
          end else begin
            rx_tcnt_n = rx_tcnt + 4'd1;
          end
        end
        RX_PARITY: begin
          if (rx_tcnt == TICK_LAST) begin
            rx_tcnt_n  = '0;
            rx_state_n = RX_STOP;
            if (rx_sync != ((^rx_shift) ^ rx_podd)) begin
              set_perr = 1'b1;
              rx_bad_n = 1'b1;
            end
          end else begin
            rx_tcnt_n = rx_tcnt + 4'd1;
          end
        end
        RX_STOP: begin
          if (rx_tcnt == TICK_LAST) begin
            rx_tcnt_n = '0;
            if (!rx_sync) begin
              set_ferr   = 1'b1;
              rx_state_n = RX_ERR;
            end else begin
              rx_push    = !rx_bad;
              rx_state_n = RX_IDLE;
            end
          end else begin
            rx_tcnt_n = rx_tcnt + 4'd1;
          end
        end
        RX_ERR: begin
          if (rx_sync) rx_state_n = RX_IDLE;
        end
        default: rx_state_n = RX_IDLE;
      endcase
    end
  end

  // TX state, datapath and registered serial output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_tcnt  <= '0;
      tx_bcnt  <= '0;
      tx_shift <= '0;
      tx_pen   <= 1'b0;
      tx_pbit  <= 1'b0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_tcnt  <= tx_tcnt_n;
      tx_bcnt  <= tx_bcnt_n;
      tx_shift <= tx_shift_n;
      tx_pen   <= tx_pen_n;
      tx_pbit  <= tx_pbit_n;
      tx       <= tx_n;
    end
  end

  // TX next state: the end of a stop bit loads the next byte directly so frames run back to back
  always_comb begin
    tx_state_n = tx_state;
    tx_tcnt_n  = tx_tcnt;
    tx_bcnt_n  = tx_bcnt;
    tx_shift_n = tx_shift;
    tx_pen_n   = tx_pen;
    tx_pbit_n  = tx_pbit;
    tx_pop     = 1'b0;
    if (tick) begin
      case (tx_state)
        TX_IDLE: begin
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_n = tx_head;
            tx_pen_n   = par_en;
            tx_pbit_n  = (^tx_head) ^ par_odd;
            tx_tcnt_n  = '0;
            tx_state_n = TX_START;
          end
        end
        TX_START: begin
          if (tx_tcnt == TICK_LAST) begin
            tx_tcnt_n  = '0;
            tx_bcnt_n  = '0;
            tx_state_n = TX_DATA;
          end else begin
            tx_tcnt_n = tx_tcnt + 4'd1;
          end
        end
        TX_DATA: begin
          if (tx_tcnt == TICK_LAST) begin
            tx_tcnt_n  = '0;
            tx_shift_n = tx_shift >> 1;
            if (tx_bcnt == BIT_LAST) tx_state_n = tx_pen ? TX_PARITY : TX_STOP;
            else                     tx_bcnt_n  = tx_bcnt + 3'd1;
          end else begin
            tx_tcnt_n = tx_tcnt + 4'd1;
          end
        end
        TX_PARITY: begin
          if (tx_tcnt == TICK_LAST) begin
            tx_tcnt_n  = '0;
            tx_state_n = TX_STOP;
          end else begin
            tx_tcnt_n = tx_tcnt + 4'd1;
          end
        end
        TX_STOP: begin
          if (tx_tcnt == TICK_LAST) begin
            tx_tcnt_n = '0;
            if (!tx_empty) begin
              tx_pop     = 1'b1;
              tx_shift_n = tx_head;
              tx_pen_n   = par_en;
              tx_pbit_n  = (^tx_head) ^ par_odd;
              tx_state_n = TX_START;
            end else begin
              tx_state_n = TX_IDLE;
            end
          end else begin
            tx_tcnt_n = tx_tcnt + 4'd1;
          end
        end
        default: tx_state_n = TX_IDLE;
      endcase
    end
    case (tx_state_n)
      TX_START:  tx_n = 1'b0;
      TX_DATA:   tx_n = tx_shift_n[0];
      TX_PARITY: tx_n = tx_pbit_n;
      default:   tx_n = 1'b1;
    endcase
  end

`ifdef UART_IRQ_EN
  // Level interrupt from receive data and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= !rx_empty || overrun || frame_err || parity_err;
  end
`endif

endmodule

// File: tb/tb_uart_buffered.sv
// tb_uart_buffered: randomized self-checking bench for uart_buffered with a
// queue-based frame-level reference model.
module tb_uart_buffered;
  localparam logic [7:0] BASE   = 8'h40;
  localparam logic [7:0] A_STAT = BASE;
  localparam logic [7:0] A_DATA = BASE + 8'd1;
  localparam logic [7:0] A_DIV  = BASE + 8'd2;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] address = '0;
  logic w_en = 1'b0;
  logic r_en = 1'b0;
  logic [7:0] dout;
  logic rx, tx;
  logic loopback = 1'b0;
  logic rx_drv = 1'b1;
`ifdef UART_IRQ_EN
  logic irq;
`endif

  assign rx = loopback ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_buffered #(
    .UART_ADDRESS(BASE),
    .DATA_BITS(8),
    .FIFO_DEPTH(DEPTH),
    .DEFAULT_DIVISOR(8'd103)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .din(din),
    .address(address),
    .w_en(w_en),
    .r_en(r_en),
    .dout(dout),
    .rx(rx),
`ifdef UART_IRQ_EN
    .irq(irq),
`endif
    .tx(tx)
  );

  int total = 0;
  int bad = 0;

  // reference model state
  logic [7:0] rx_q[$];
  logic [7:0] lb_q[$];
  bit m_pen = 0, m_podd = 0, m_ovr = 0, m_ferr = 0, m_perr = 0;
  int bit_clks = 16 * 104;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_stat(input bit txi, input bit txf);
    return {m_podd, m_pen, m_perr, m_ferr, m_ovr, txi, txf, (rx_q.size() != 0)};
  endfunction

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a; din = d; w_en = 1'b1;
    @(negedge clk);
    w_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    address = a; r_en = 1'b1;
    @(negedge clk);
    r_en = 1'b0;
    d = dout;
  endtask

  task automatic set_cfg(input bit pen, input bit podd);
    wr(A_STAT, {podd, pen, 6'b0});
    m_pen = pen; m_podd = podd;
  endtask

  task automatic clear_flags(input logic [2:0] m);
    wr(A_STAT, {m_podd, m_pen, m, 3'b0});
    if (m[0]) m_ovr = 0;
    if (m[1]) m_ferr = 0;
    if (m[2]) m_perr = 0;
  endtask

  task automatic check_stat(input string tag);
    logic [7:0] s;
    rd(A_STAT, s);
    check(tag, s, exp_stat(1'b1, 1'b0));
  endtask

  task automatic drive_bit(input logic v);
    rx_drv = v;
    repeat (bit_clks) @(negedge clk);
  endtask

  // one serial frame on rx plus two idle bits, then update the model
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop);
    bit pbad;
    pbad = m_pen && bad_par;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (m_pen) drive_bit((^d) ^ m_podd ^ bad_par);
    drive_bit(stop);
    drive_bit(1'b1);
    drive_bit(1'b1);
    if (pbad) m_perr = 1;
    if (!stop) m_ferr = 1;
    else if (!pbad) begin
      if (rx_q.size() == DEPTH) m_ovr = 1;
      else rx_q.push_back(d);
    end
  endtask

  task automatic drain(input string tag);
    logic [7:0] v, e;
    while (rx_q.size() != 0) begin
      rd(A_DATA, v);
      e = rx_q.pop_front();
      check(tag, v, e);
    end
    rd(A_DATA, v);
    check({tag, "_empty"}, v, 8'h00);
  endtask

  // push lb_q into TX with tx looped to rx; drain RX while polling
  task automatic lb_run(input bit expect_full);
    logic [7:0] expq[$];
    logic [7:0] s, v, e;
    bit done;
    int got, nexp;
    loopback = 1'b1;
    for (int i = 0; i < lb_q.size(); i++) begin
      wr(A_DATA, lb_q[i]);
      if (i <= DEPTH) expq.push_back(lb_q[i]);
    end
    nexp = expq.size();
    if (expect_full) begin
      rd(A_STAT, s);
      check("lb_tx_full_stat", s, exp_stat(1'b0, 1'b1));
    end
    done = 0;
    got = 0;
    for (int it = 0; it < 8000 && !done; it++) begin
      rd(A_STAT, s);
      if (s[0]) begin
        rd(A_DATA, v);
        got++;
        if (expq.size() != 0) begin
          e = expq.pop_front();
          check("lb_data", v, e);
        end
      end else if (s[2] && expq.size() == 0) begin
        done = 1;
      end
    end
    check("lb_done", done, 1);
    check("lb_count", got, nexp);
    rd(A_STAT, s);
    check("lb_stat", s, exp_stat(1'b1, 1'b0));
    loopback = 1'b0;
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    logic [7:0] d;
    int kind;

    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_dout", dout, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_stat("rst_stat");
    rd(A_DIV, v);
    check("rst_div", v, 103);

    wr(A_DIV, 8'd3);
    bit_clks = 16 * 4;
    repeat (120) @(negedge clk);
    rd(A_DIV, v);
    check("div_rd", v, 3);
    wr(BASE + 8'd3, 8'hFF);
    rd(BASE + 8'd3, v);
    check("oow_hold", v, 3);
    check_stat("oow_stat");

    // loopback of two bytes
    lb_q = {};
    lb_q.push_back(8'hA5);
    lb_q.push_back(8'h3C);
    lb_run(1'b0);

    // loopback with parity, TX FIFO overfilled by one
    set_cfg(1'b1, 1'($urandom_range(0, 1)));
    lb_q = {};
    for (int i = 0; i < DEPTH + 2; i++) lb_q.push_back(8'($urandom));
    lb_run(1'b1);
    set_cfg(1'b0, 1'b0);

    // parity error
    set_cfg(1'b1, 1'b1);
    send_frame(8'h55, 1'b1, 1'b1);
    check_stat("par_stat");
    drain("par_data");
    wr(A_STAT, 8'h20);
    m_pen = 0; m_podd = 0; m_perr = 0;
    check_stat("par_clr");

    // framing error then recovery
    send_frame(8'h81, 1'b0, 1'b0);
    check_stat("frm_stat");
    drain("frm_data");
    send_frame(8'h12, 1'b0, 1'b1);
    check_stat("frm_next_stat");
    drain("frm_next");
    clear_flags(3'b111);
    check_stat("frm_clr");

    // overrun
    for (int i = 0; i < DEPTH + 1; i++) send_frame(8'($urandom), 1'b0, 1'b1);
    check_stat("ovr_stat");
    drain("ovr_data");
    clear_flags(3'b001);
    check_stat("ovr_clr");

    // false start glitch then a valid frame
    rx_drv = 1'b0;
    repeat (12) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * bit_clks) @(negedge clk);
    check_stat("glitch_stat");
    send_frame(8'h6B, 1'b0, 1'b1);
    drain("glitch_next");

    // randomized frames and configurations
    for (int n = 0; n < 12; n++) begin
      set_cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      kind = $urandom_range(0, 3);
      d = 8'($urandom);
      send_frame(d, kind == 2, kind != 3);
      if ($urandom_range(0, 2) == 0) begin
        check_stat("rnd_stat");
        drain("rnd_data");
      end
      if ($urandom_range(0, 3) == 0) clear_flags(3'($urandom));
    end
    check_stat("rnd_end_stat");
    drain("rnd_end");

    // reset in the middle of a TX frame
    send_frame(8'h00, 1'b0, 1'b0);
    set_cfg(1'b1, 1'b0);
    wr(A_DATA, 8'h5A);
    wr(A_DATA, 8'h11);
    wr(A_DATA, 8'h22);
    rd(A_DIV, v);
    repeat (20) @(negedge clk);
    check("tx_start_low", tx, 0);
    #3 rst_n = 1'b0;
    #1;
    check("rst_async_tx", tx, 1);
    check("rst_async_dout", dout, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_pen = 0; m_podd = 0; m_ovr = 0; m_ferr = 0; m_perr = 0;
    rx_q = {};
    check_stat("rst2_stat");
    rd(A_DIV, v);
    check("rst2_div", v, 103);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
